// File: rtl/offset_calibrator_if.sv
// Sample-path bus for offset_calibrator: ADC strobe/sample/recalibrate in,
// offset estimate and bias-removed samples out.
interface offset_calibrator_if #(
  parameter int unsigned WIDTH = 10
);
  logic               sampleValid;
  logic [WIDTH-1:0]   sampleVoltage;
  logic               recalibrate;
  logic [WIDTH-1:0]   offset;
  logic               calibrated;
  logic [WIDTH:0]     centered;
  logic               centeredValid;

  // Sample source side (ADC register / testbench)
  modport master (
    output sampleValid, sampleVoltage, recalibrate,
    input  offset, calibrated, centered, centeredValid
  );

  // Calibrator side
  modport slave (
    input  sampleValid, sampleVoltage, recalibrate,
    output offset, calibrated, centered, centeredValid
  );
endinterface

// File: rtl/offset_calibrator.sv
// DC-offset calibrator: averages 2^LOG2_SAMPLES samples to estimate the ADC
// bias, then publishes bias-removed samples.
// Optional drift tracking after calibration: define OFFSET_CALIBRATOR_TRACKING_EN.
module offset_calibrator #(
  parameter int unsigned WIDTH        = 10,
  parameter int unsigned LOG2_SAMPLES = 12
) (
  input logic                  clk,
  input logic                  reset,
  offset_calibrator_if.slave   bus
);

  localparam int unsigned AccW = WIDTH + LOG2_SAMPLES;

  typedef enum logic [0:0] {StCal, StDone} state_e;

  state_e                  state_q, state_d;
  logic [AccW-1:0]         acc_q, acc_d;
  logic [LOG2_SAMPLES-1:0] count_q, count_d;
  logic [WIDTH-1:0]        offset_q, offset_d;
  logic                    calibrated_q, calibrated_d;
  logic [WIDTH:0]          centered_q, centered_d;
  logic                    centered_valid_q, centered_valid_d;

  logic [AccW-1:0]         sample_ext;
  logic [AccW-1:0]         cal_sum;

  assign sample_ext = {{LOG2_SAMPLES{1'b0}}, bus.sampleVoltage};
  assign cal_sum    = acc_q + sample_ext;

`ifdef OFFSET_CALIBRATOR_TRACKING_EN
  // Leaky integrator: acc settles at N times the mean sample, so it cannot overflow
  logic [AccW-1:0] track_sum;
  assign track_sum = acc_q - (acc_q >> LOG2_SAMPLES) + sample_ext;
`endif

  // Next-state: calibration accumulation, recalibration and sample centering
  always_comb begin
    state_d          = state_q;
    acc_d            = acc_q;
    count_d          = count_q;
    offset_d         = offset_q;
    calibrated_d     = calibrated_q;
    centered_d       = centered_q;
    centered_valid_d = 1'b0;

    if (bus.recalibrate) begin
      // Recalibrate swallows any coincident sample; offset keeps the last result
      state_d      = StCal;
      acc_d        = '0;
      count_d      = '0;
      calibrated_d = 1'b0;
    end else if (bus.sampleValid) begin
      if (calibrated_q) begin
        centered_d       = {1'b0, bus.sampleVoltage} - {1'b0, offset_q};
        centered_valid_d = 1'b1;
      end
      unique case (state_q)
        StCal: begin
          acc_d   = cal_sum;
          count_d = count_q + 1'b1;
          if (count_q == '1) begin
            state_d      = StDone;
            offset_d     = cal_sum[AccW-1 -: WIDTH];
            calibrated_d = 1'b1;
          end
        end
        StDone: begin
`ifdef OFFSET_CALIBRATOR_TRACKING_EN
          acc_d    = track_sum;
          offset_d = track_sum[AccW-1 -: WIDTH];
`endif
        end
        default: state_d = StCal;
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StCal;
      acc_q            <= '0;
      count_q          <= '0;
      offset_q         <= '0;
      calibrated_q     <= 1'b0;
      centered_q       <= '0;
      centered_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      acc_q            <= acc_d;
      count_q          <= count_d;
      offset_q         <= offset_d;
      calibrated_q     <= calibrated_d;
      centered_q       <= centered_d;
      centered_valid_q <= centered_valid_d;
    end
  end

  assign bus.offset        = offset_q;
  assign bus.calibrated    = calibrated_q;
  assign bus.centered      = centered_q;
  assign bus.centeredValid = centered_valid_q;

endmodule
